umi_rr_arbiter: RTL and testbench
=================================

UMI_RR_ARBITER -- requirements
Module: umi_rr_arbiter

Interface
REQ-001 Parameter N, default 4: number of UMI requester input ports.
REQ-002 Parameter DW, default 256: UMI data width.
REQ-003 Parameter CW, default 32: UMI command width.
REQ-004 Parameter AW, default 64: UMI address width.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 umi_in_valid  input  N  per-requester valid.
REQ-009 umi_in_cmd  input  N*CW  per-requester command, slice i at [i*CW+:CW].
REQ-010 umi_in_dstaddr  input  N*AW  per-requester destination address.
REQ-011 umi_in_srcaddr  input  N*AW  per-requester source address.
REQ-012 umi_in_data  input  N*DW  per-requester data.
REQ-013 umi_in_ready  output  N  per-requester ready.
REQ-014 umi_out_valid  output  1  registered output valid.
REQ-015 umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data  output  CW/AW/AW/DW  registered output payload.
REQ-016 umi_out_ready  input  1  downstream ready.
REQ-017 lock_active  output  1  high while a multi-beat transaction holds the grant.

Function
REQ-018 Load enable ld = ~umi_out_valid | umi_out_ready; the output register accepts a new beat only when ld=1.
REQ-019 State IDLE: eligible set = all i with umi_in_valid[i]=1; winner = first eligible index at or after pointer rr, searching upward with wrap from N-1 to 0.
REQ-020 State LOCKED(k): only requester k is eligible; all other umi_in_ready bits SHALL be 0.
REQ-021 umi_in_ready[i] = ld AND (i is the winner); at most one umi_in_ready bit is high per cycle.
REQ-022 A transfer on input i (valid and ready) SHALL load that input's cmd/dstaddr/srcaddr/data into the output register and set umi_out_valid=1 at the next edge; latency is exactly 1 cycle.
REQ-023 When ld=1 and no transfer occurs, umi_out_valid SHALL clear at the next edge; payload registers hold their values.
REQ-024 While umi_out_valid=1 and umi_out_ready=0, every output SHALL remain stable.
REQ-025 Throughput: one beat per cycle when umi_out_ready is held at 1; drain and refill in the same cycle are allowed.
REQ-026 Transfer from i with cmd bit 22 (EOM) = 0 -> LOCKED(i), lock_active=1.
REQ-027 Transfer from i with EOM=1 -> IDLE, rr <= (i+1) mod N, lock_active=0.
REQ-028 Pointer rr SHALL advance only on an EOM transfer, never on a non-EOM beat or an idle cycle.
REQ-029 In LOCKED(k) with umi_in_valid[k]=0, no transfer occurs, the lock is held, and other requesters wait.
REQ-030 rr width is ceil(log2 N), minimum 1; N=1 SHALL operate as a registered pass-through.
REQ-031 The arbiter SHALL NOT inspect, modify or reorder payload fields other than cmd bit 22.

Reset
REQ-032 Reset assertion SHALL immediately force umi_out_valid=0, lock_active=0, rr=0, state=IDLE, all umi_out payload bits=0, and all umi_in_ready=0.
REQ-033 A transaction interrupted by reset SHALL be abandoned; after reset release, arbitration restarts from index 0 with no residual lock.
REQ-034 The first grant is possible in the first cycle after reset deasserts.

Verification
REQ-035 Stimulus: all 4 inputs continuously valid with single-beat EOM=1 commands, umi_out_ready=1 -> output sources in the order 0,1,2,3,0,1, one beat per cycle.
REQ-036 Stimulus: inputs 1 and 2 valid; input 1 sends a 3-beat packet (EOM on beat 3); input 0 idle -> three contiguous input-1 beats, lock_active=1 for beats 1-2, then input 2 is granted and rr=3 after its EOM.
REQ-037 Stimulus: output valid, umi_out_ready=0 for 5 cycles with all inputs valid -> outputs frozen and umi_in_ready=0000 for all 5 cycles; the held beat is delivered on the first ready cycle.
REQ-038 Stimulus: reset asserted mid-way through input 2's 4-beat packet -> outputs clear asynchronously; after release, an input-0 request is granted first and lock_active=0.
REQ-039 Stimulus: only input 3 valid, dstaddr=0x1234 -> umi_in_ready[3]=1 in the same cycle; umi_out_valid=1 with umi_out_dstaddr=0x1234 one cycle later.
REQ-040 Stimulus: locked input 1 deasserts valid for 3 cycles mid-packet while input 0 is valid -> no output beats for those 3 cycles, and umi_in_ready[0] stays 0 until input 1's EOM.

Source files
------------

// File: rtl/umi_rr_arbiter_if.sv
// UMI bundle between N requesters and one downstream port.
// Transfer rule: a beat moves on a rising edge where valid and ready are both high;
// ready may depend combinationally on valid, valid never depends on ready.
interface umi_rr_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 256,
    parameter int CW = 32,
    parameter int AW = 64
);
    logic [N-1:0]    umi_in_valid;
    logic [N*CW-1:0] umi_in_cmd;
    logic [N*AW-1:0] umi_in_dstaddr;
    logic [N*AW-1:0] umi_in_srcaddr;
    logic [N*DW-1:0] umi_in_data;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [CW-1:0]   umi_out_cmd;
    logic [AW-1:0]   umi_out_dstaddr;
    logic [AW-1:0]   umi_out_srcaddr;
    logic [DW-1:0]   umi_out_data;
    logic            umi_out_ready;

    modport master (
        output umi_in_valid, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data,
        input  umi_in_ready,
        input  umi_out_valid, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data,
        output umi_out_ready
    );

    modport slave (
        input  umi_in_valid, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data,
        output umi_in_ready,
        output umi_out_valid, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data,
        input  umi_out_ready
    );
endinterface

// File: rtl/umi_rr_arbiter.sv
// Round-robin UMI arbiter: N requesters onto one registered output; a multi-beat
// packet (cmd bit 22 low) keeps the grant until its EOM beat.
module umi_rr_arbiter #(
    parameter int N  = 4,
    parameter int DW = 256,
    parameter int CW = 32,
    parameter int AW = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    umi_rr_arbiter_if.slave                     umi,
    output logic                                lock_active,
    output logic                                o_dbg_state,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_dbg_rr
);
    localparam int RW      = (N > 1) ? $clog2(N) : 1;
    localparam int EOM_BIT = 22;
    localparam logic [RW-1:0] LAST = RW'(N - 1);

    typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [RW-1:0] r_lock_idx, w_lock_idx_nxt;
    logic [RW-1:0] r_rr, w_rr_nxt;
    logic [RW-1:0] w_win;
    logic          w_found;
    logic          w_ld;
    logic          w_xfer;
    logic [N-1:0]  w_ready;

    logic [CW-1:0] w_cmd;
    logic [AW-1:0] w_dst;
    logic [AW-1:0] w_src;
    logic [DW-1:0] w_data;

    logic          r_out_valid;
    logic [CW-1:0] r_out_cmd;
    logic [AW-1:0] r_out_dst;
    logic [AW-1:0] r_out_src;
    logic [DW-1:0] r_out_data;

    assign w_ld = ~r_out_valid | umi.umi_out_ready;

    // Descending scan so the smallest rotation offset from r_rr is the last to write.
    always_comb begin : p_winner
        int idx;
        idx     = 0;
        w_win   = r_rr;
        w_found = 1'b0;
        if (r_state == S_LOCKED) begin
            w_win   = r_lock_idx;
            w_found = umi.umi_in_valid[r_lock_idx];
        end else begin
            for (int off = N - 1; off >= 0; off--) begin
                idx = int'(r_rr) + off;
                if (idx >= N) idx = idx - N;
                if (umi.umi_in_valid[RW'(idx)]) begin
                    w_win   = RW'(idx);
                    w_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < N; i++) begin
            w_ready[i] = ~reset & w_ld & w_found & (w_win == RW'(i));
        end
    end

    assign w_xfer = |w_ready;
    assign w_cmd  = umi.umi_in_cmd[int'(w_win)*CW +: CW];
    assign w_dst  = umi.umi_in_dstaddr[int'(w_win)*AW +: AW];
    assign w_src  = umi.umi_in_srcaddr[int'(w_win)*AW +: AW];
    assign w_data = umi.umi_in_data[int'(w_win)*DW +: DW];

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_idx_nxt = r_lock_idx;
        w_rr_nxt       = r_rr;
        if (w_xfer) begin
            if (w_cmd[EOM_BIT]) begin
                w_state_nxt = S_IDLE;
                w_rr_nxt    = (w_win == LAST) ? '0 : w_win + 1'b1;
            end else begin
                w_state_nxt    = S_LOCKED;
                w_lock_idx_nxt = w_win;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lock_idx <= '0;
            r_rr       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_idx <= w_lock_idx_nxt;
            r_rr       <= w_rr_nxt;
        end
    end

    // Payload only moves on a transfer; an unfilled load just drops valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_cmd   <= '0;
            r_out_dst   <= '0;
            r_out_src   <= '0;
            r_out_data  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_cmd   <= w_cmd;
            r_out_dst   <= w_dst;
            r_out_src   <= w_src;
            r_out_data  <= w_data;
        end else if (w_ld) begin
            r_out_valid <= 1'b0;
        end
    end

    assign umi.umi_in_ready    = w_ready;
    assign umi.umi_out_valid   = r_out_valid;
    assign umi.umi_out_cmd     = r_out_cmd;
    assign umi.umi_out_dstaddr = r_out_dst;
    assign umi.umi_out_srcaddr = r_out_src;
    assign umi.umi_out_data    = r_out_data;
    assign lock_active         = (r_state == S_LOCKED);
    assign o_dbg_state         = (r_state == S_LOCKED);
    assign o_dbg_rr            = r_rr;
endmodule

// File: tb/tb_umi_rr_arbiter.sv
// Randomized and directed bench for umi_rr_arbiter against a packet-level
// reference model with an expected-beat queue.
module tb_umi_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int CW = 32;
    localparam int AW = 32;
    localparam int RW = 2;
    localparam int BW = CW + AW + AW + DW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    umi_rr_arbiter_if #(.N(N), .DW(DW), .CW(CW), .AW(AW)) umi ();
    logic          lock_active;
    logic          dbg_state;
    logic [RW-1:0] dbg_rr;

    umi_rr_arbiter #(.N(N), .DW(DW), .CW(CW), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .umi        (umi),
        .lock_active(lock_active),
        .o_dbg_state(dbg_state),
        .o_dbg_rr   (dbg_rr)
    );

    // Driven stimulus
    logic [N-1:0]  d_valid;
    logic [CW-1:0] d_cmd  [N];
    logic [AW-1:0] d_dst  [N];
    logic [AW-1:0] d_src  [N];
    logic [DW-1:0] d_data [N];
    logic          out_ready;

    always_comb begin
        umi.umi_in_valid   = d_valid;
        umi.umi_in_cmd     = '0;
        umi.umi_in_dstaddr = '0;
        umi.umi_in_srcaddr = '0;
        umi.umi_in_data    = '0;
        for (int i = 0; i < N; i++) begin
            umi.umi_in_cmd[i*CW +: CW]     = d_cmd[i];
            umi.umi_in_dstaddr[i*AW +: AW] = d_dst[i];
            umi.umi_in_srcaddr[i*AW +: AW] = d_src[i];
            umi.umi_in_data[i*DW +: DW]    = d_data[i];
        end
        umi.umi_out_ready = out_ready;
    end

    // Packet generator: beats left in the current packet, auto-refill length, valid gating
    int pkt_left [N];
    int refill   [N];
    bit hold     [N];

    // Reference model: lock owner, round-robin pointer, in-flight output beats
    bit               m_locked;
    int               m_owner;
    int               m_rr;
    logic [BW-1:0]    exp_q[$];
    int               src_q[$];
    int               src_log[$];
    logic [N-1:0]     last_rdy;

    int tests_run;
    int tests_failed;

    function automatic void new_payload(int i);
        d_cmd[i]  = $urandom;
        d_dst[i]  = $urandom;
        d_src[i]  = $urandom;
        d_data[i] = {$urandom, $urandom};
    endfunction

    function automatic void drive();
        for (int i = 0; i < N; i++) begin
            d_valid[i]   = (pkt_left[i] > 0) && !hold[i];
            d_cmd[i][22] = (pkt_left[i] == 1);
        end
    endfunction

    // Next grant per the arbitration rules: lock owner only, else first valid from m_rr upward.
    function automatic int model_winner();
        if (m_locked) return d_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (d_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // Called #1 after a rising edge; checks at the falling edge, advances the model after the next rising edge.
    task automatic cycle();
        int            w;
        bit            ld;
        logic [N-1:0]  exp_rdy;
        logic [BW-1:0] got;
        drive();
        @(negedge clk);
        w  = model_winner();
        ld = (exp_q.size() == 0) || out_ready;
        exp_rdy = '0;
        if (ld && w >= 0) exp_rdy[w] = 1'b1;
        last_rdy = umi.umi_in_ready;
        tests_run++;
        if (umi.umi_in_ready !== exp_rdy) begin
          tests_failed++;
          $display("FAIL in_ready: got %b expected %b at %0t", umi.umi_in_ready, exp_rdy, $time);
        end
        tests_run++;
        if (umi.umi_out_valid !== (exp_q.size() != 0)) begin
          tests_failed++;
          $display("FAIL out_valid: got %b expected %b at %0t", umi.umi_out_valid, exp_q.size() != 0, $time);
        end
        if (exp_q.size() != 0) begin
            got = {umi.umi_out_cmd, umi.umi_out_dstaddr, umi.umi_out_srcaddr, umi.umi_out_data};
            tests_run++;
            if (got !== exp_q[0]) begin
              tests_failed++;
              $display("FAIL out_payload: got %h expected %h at %0t", got, exp_q[0], $time);
            end
        end
        tests_run++;
        if (lock_active !== m_locked || dbg_state !== m_locked) begin
          tests_failed++;
          $display("FAIL lock_active: got %b/%b expected %b at %0t", lock_active, dbg_state, m_locked, $time);
        end
        tests_run++;
        if (dbg_rr !== RW'(m_rr)) begin
          tests_failed++;
          $display("FAIL rr: got %0d expected %0d at %0t", dbg_rr, m_rr, $time);
        end
        @(posedge clk);
        #1;
        if (exp_q.size() != 0 && out_ready) begin
            void'(exp_q.pop_front());
            src_log.push_back(src_q.pop_front());
        end
        if (ld && w >= 0) begin
            exp_q.push_back({d_cmd[w], d_dst[w], d_src[w], d_data[w]});
            src_q.push_back(w);
            if (d_cmd[w][22]) begin
                m_locked = 1'b0;
                m_rr     = (w + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = w;
            end
            pkt_left[w]--;
            new_payload(w);
            if (pkt_left[w] == 0) pkt_left[w] = refill[w];
        end
    endtask

    // Asserts reset away from a clock edge and checks the asynchronous clear.
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        tests_run++;
        if (umi.umi_out_valid !== 1'b0 || lock_active !== 1'b0 || umi.umi_in_ready !== '0) begin
          tests_failed++;
          $display("FAIL reset_ctrl: valid=%b lock=%b ready=%b expected 0/0/0000", umi.umi_out_valid, lock_active, umi.umi_in_ready);
        end
        tests_run++;
        if ({umi.umi_out_cmd, umi.umi_out_dstaddr, umi.umi_out_srcaddr, umi.umi_out_data} !== '0 || dbg_rr !== '0) begin
          tests_failed++;
          $display("FAIL reset_payload: cmd=%h dst=%h rr=%0d expected zeros", umi.umi_out_cmd, umi.umi_out_dstaddr, dbg_rr);
        end
        m_locked = 1'b0; m_owner = 0; m_rr = 0;
        exp_q.delete(); src_q.delete();
        for (int i = 0; i < N; i++) begin
            pkt_left[i] = 0; refill[i] = 0; hold[i] = 1'b0;
        end
        drive();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) pkt_left[i] = 2;
        drive();
        apply_reset();
        out_ready = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic test_round_robin();
        int got;
        apply_reset();
        for (int i = 0; i < N; i++) begin pkt_left[i] = 1; refill[i] = 1; end
        out_ready = 1'b1;
        src_log.delete();
        repeat (7) cycle();
        for (int k = 0; k < 6; k++) begin
            got = (src_log.size() > k) ? src_log[k] : -1;
            tests_run++;
            if (got !== k % N) begin
              tests_failed++;
              $display("FAIL rr_order[%0d]: got %0d expected %0d", k, got, k % N);
            end
        end
        for (int i = 0; i < N; i++) begin pkt_left[i] = 0; refill[i] = 0; end
        repeat (3) cycle();
    endtask

    task automatic test_lock();
        int exp_src[4];
        int got;
        exp_src = '{1, 1, 1, 2};
        apply_reset();
        pkt_left[1] = 3; pkt_left[2] = 1;
        out_ready = 1'b1;
        src_log.delete();
        repeat (7) cycle();
        for (int k = 0; k < 4; k++) begin
            got = (src_log.size() > k) ? src_log[k] : -1;
            tests_run++;
            if (got !== exp_src[k]) begin
              tests_failed++;
              $display("FAIL lock_order[%0d]: got %0d expected %0d", k, got, exp_src[k]);
            end
        end
        tests_run++;
        if (dbg_rr !== 2'd3) begin
          tests_failed++;
          $display("FAIL lock_rr: got %0d expected 3", dbg_rr);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 0; i < N; i++) begin pkt_left[i] = 1; refill[i] = 1; end
        out_ready = 1'b1;
        src_log.delete();
        cycle();
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            cycle();
            tests_run++;
            if (last_rdy !== '0 || exp_q.size() != 1 || umi.umi_out_valid !== 1'b1 ||
                {umi.umi_out_cmd, umi.umi_out_dstaddr, umi.umi_out_srcaddr, umi.umi_out_data} !== exp_q[0]) begin
              tests_failed++;
              $display("FAIL stall[%0d]: ready=%b valid=%b expected 0000/1 with held beat", s, last_rdy, umi.umi_out_valid);
            end
        end
        out_ready = 1'b1;
        cycle();
        tests_run++;
        if (src_log.size() != 1 || src_log[0] != 0) begin
          tests_failed++;
          $display("FAIL stall_release: delivered %0d beats expected 1 from source 0", src_log.size());
        end
        for (int i = 0; i < N; i++) begin pkt_left[i] = 0; refill[i] = 0; end
        repeat (3) cycle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        pkt_left[2] = 4;
        out_ready = 1'b1;
        repeat (2) cycle();
        apply_reset();
        tests_run++;
        if (lock_active !== 1'b0) begin
          tests_failed++;
          $display("FAIL reset_mid_lock: got %b expected 0", lock_active);
        end
        pkt_left[0] = 1; pkt_left[2] = 4;
        src_log.delete();
        repeat (3) cycle();
        tests_run++;
        if (src_log.size() == 0 || src_log[0] != 0) begin
          tests_failed++;
          $display("FAIL reset_mid_first: got %0d expected 0", (src_log.size() == 0) ? -1 : src_log[0]);
        end
        repeat (6) cycle();
    endtask

    task automatic test_single();
        apply_reset();
        out_ready = 1'b1;
        pkt_left[3] = 1;
        new_payload(3);
        d_dst[3] = 32'h1234;
        drive();
        #1;
        tests_run++;
        if (umi.umi_in_ready !== 4'b1000) begin
          tests_failed++;
          $display("FAIL single_ready: got %b expected 1000", umi.umi_in_ready);
        end
        cycle();
        tests_run++;
        if (umi.umi_out_valid !== 1'b1 || umi.umi_out_dstaddr !== 32'h1234) begin
          tests_failed++;
          $display("FAIL single_out: valid=%b dst=%h expected 1/00001234", umi.umi_out_valid, umi.umi_out_dstaddr);
        end
        repeat (2) cycle();
    endtask

    task automatic test_lock_hold();
        int exp_src[4];
        int got;
        exp_src = '{1, 1, 1, 0};
        apply_reset();
        out_ready = 1'b1;
        src_log.delete();
        pkt_left[1] = 3;
        cycle();
        pkt_left[0] = 1;
        hold[1] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            cycle();
            tests_run++;
            if (last_rdy !== '0) begin
              tests_failed++;
              $display("FAIL hold_ready[%0d]: got %b expected 0000", s, last_rdy);
            end
        end
        hold[1] = 1'b0;
        repeat (6) cycle();
        for (int k = 0; k < 4; k++) begin
            got = (src_log.size() > k) ? src_log[k] : -1;
            tests_run++;
            if (got !== exp_src[k]) begin
              tests_failed++;
              $display("FAIL hold_order[%0d]: got %0d expected %0d", k, got, exp_src[k]);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pkt_left[i] == 0 && $urandom_range(0, 3) == 0) pkt_left[i] = $urandom_range(1, 4);
                hold[i] = ($urandom_range(0, 4) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        out_ready = 1'b0;
        m_locked = 1'b0; m_owner = 0; m_rr = 0;
        last_rdy = '0;
        for (int i = 0; i < N; i++) begin
            pkt_left[i] = 0; refill[i] = 0; hold[i] = 1'b0;
            new_payload(i);
        end
        drive();
        #2;
        test_reset();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_reset_mid();
        test_single();
        test_lock_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
